// File: rtl/brisc_line_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : brisc_line_mem_if
//  Description : Request/response bundle between a cache-line client and the
//                brisc_line_mem main-memory model. resp_err is present only
//                when BRISC_LINE_MEM_BOUNDS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface brisc_line_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic [LINE_WIDTH-1:0] resp_data;
`ifdef BRISC_LINE_MEM_BOUNDS_EN
  logic                  resp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_data, resp_err
  );
`else
  modport master (
    output req_valid, req_rw, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_data
  );
`endif

endinterface
`default_nettype wire

// File: rtl/brisc_line_mem.sv
`default_nettype none
// ============================================================================
//  Module      : brisc_line_mem
//  Description : Cache-line main-memory model with fixed request and response
//                latency, up to MAX_OUTSTANDING pipelined in-order requests
//                and a show-ahead response FIFO providing backpressure.
//                Optional macro BRISC_LINE_MEM_BOUNDS_EN adds range checking
//                (resp_err) and allows a non-power-of-2 DEPTH_LINES.
//  Revision    : 1.0 - initial release
// ============================================================================
module brisc_line_mem #(
  parameter int LINE_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int DEPTH_LINES     = 2048,
  parameter int REQ_DELAY       = 5,
  parameter int RESP_DELAY      = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input wire               clk,
  input wire               rst_n,
  brisc_line_mem_if.slave  bus
);

  localparam int c_OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int c_IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  generate
`ifndef BRISC_LINE_MEM_BOUNDS_EN
    if ((DEPTH_LINES & (DEPTH_LINES - 1)) != 0) begin : g_depth_pow2_chk
      $error("brisc_line_mem: DEPTH_LINES must be a power of 2");
    end
`endif
    if (REQ_DELAY < 1 || RESP_DELAY < 1 || MAX_OUTSTANDING < 1) begin : g_param_chk
      $error("brisc_line_mem: REQ_DELAY, RESP_DELAY and MAX_OUTSTANDING must be >= 1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshakes and outstanding-request accounting
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_fifo_cnt;
  logic               w_resp_valid;
  logic               w_accept;
  logic               w_pop;

  // req_ready depends only on the registered counter, never on resp_ready.
  assign bus.req_ready = (r_outstanding < c_CNT_W'(MAX_OUTSTANDING));
  assign w_resp_valid  = (r_fifo_cnt != '0);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_pop         = w_resp_valid && bus.resp_ready;

  // Count accepted-but-unacknowledged requests; simultaneous +1/-1 cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else if (w_accept && !w_pop) begin
      r_outstanding <= r_outstanding + c_CNT_W'(1);
    end else if (!w_accept && w_pop) begin
      r_outstanding <= r_outstanding - c_CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Request pipeline: REQ_DELAY stages, last stage performs the array access
  // --------------------------------------------------------------------------
  logic                  r_rq_valid [REQ_DELAY];
  logic                  r_rq_rw    [REQ_DELAY];
  logic [ADDR_WIDTH-1:0] r_rq_addr  [REQ_DELAY];
  logic [LINE_WIDTH-1:0] r_rq_data  [REQ_DELAY];

  // Shift accepted requests toward the array; never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_DELAY; i++) begin
        r_rq_valid[i] <= 1'b0;
        r_rq_rw[i]    <= 1'b0;
        r_rq_addr[i]  <= '0;
        r_rq_data[i]  <= '0;
      end
    end else begin
      r_rq_valid[0] <= w_accept;
      r_rq_rw[0]    <= bus.req_rw;
      r_rq_addr[0]  <= bus.req_addr;
      r_rq_data[0]  <= bus.req_data;
      for (int i = 1; i < REQ_DELAY; i++) begin
        r_rq_valid[i] <= r_rq_valid[i-1];
        r_rq_rw[i]    <= r_rq_rw[i-1];
        r_rq_addr[i]  <= r_rq_addr[i-1];
        r_rq_data[i]  <= r_rq_data[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line array access
  // --------------------------------------------------------------------------
  logic [LINE_WIDTH-1:0] r_mem [DEPTH_LINES];
  logic                  w_acc_valid;
  logic                  w_acc_rw;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [LINE_WIDTH-1:0] w_acc_data;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_oob;
`ifdef BRISC_LINE_MEM_BOUNDS_EN
  logic [ADDR_WIDTH-1:0] w_line;
`endif

  assign w_acc_valid = r_rq_valid[REQ_DELAY-1];
  assign w_acc_rw    = r_rq_rw[REQ_DELAY-1];
  assign w_acc_addr  = r_rq_addr[REQ_DELAY-1];

  // Decode the line index and, when range checking is built in, flag
  // full line addresses beyond the array.
  always_comb begin
`ifdef BRISC_LINE_MEM_BOUNDS_EN
    w_line = w_acc_addr >> c_OFF_W;
    w_idx  = (DEPTH_LINES == 1) ? '0 : w_line[c_IDX_W-1:0];
    w_oob  = (w_line >= ADDR_WIDTH'(DEPTH_LINES));
`else
    w_idx  = (DEPTH_LINES == 1) ? '0 : w_acc_addr[c_OFF_W +: c_IDX_W];
    w_oob  = 1'b0;
`endif
  end

  // Response payload: writes echo their data, out-of-range reads return zero.
  always_comb begin
    w_acc_data = r_mem[w_idx];
    if (w_acc_rw) begin
      w_acc_data = r_rq_data[REQ_DELAY-1];
    end else if (w_oob) begin
      w_acc_data = '0;
    end
  end

  // Array contents are deliberately outside reset so completed writes survive.
  always_ff @(posedge clk) begin
    if (w_acc_valid && w_acc_rw && !w_oob) begin
      r_mem[w_idx] <= r_rq_data[REQ_DELAY-1];
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline: the access edge plus RESP_DELAY-1 registers, so that
  // the FIFO is written RESP_DELAY edges after the access.
  // --------------------------------------------------------------------------
  logic                  w_fin_valid;
  logic [ADDR_WIDTH-1:0] w_fin_addr;
  logic [LINE_WIDTH-1:0] w_fin_data;
  logic                  w_fin_err;

  generate
    if (RESP_DELAY > 1) begin : g_resp_pipe
      localparam int c_N = RESP_DELAY - 1;
      logic                  r_valid [c_N];
      logic [ADDR_WIDTH-1:0] r_addr  [c_N];
      logic [LINE_WIDTH-1:0] r_data  [c_N];
      logic                  r_err   [c_N];

      // Carry access results toward the response FIFO; never stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c_N; i++) begin
            r_valid[i] <= 1'b0;
            r_addr[i]  <= '0;
            r_data[i]  <= '0;
            r_err[i]   <= 1'b0;
          end
        end else begin
          r_valid[0] <= w_acc_valid;
          r_addr[0]  <= w_acc_addr;
          r_data[0]  <= w_acc_data;
          r_err[0]   <= w_oob;
          for (int i = 1; i < c_N; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_addr[i]  <= r_addr[i-1];
            r_data[i]  <= r_data[i-1];
            r_err[i]   <= r_err[i-1];
          end
        end
      end

      assign w_fin_valid = r_valid[c_N-1];
      assign w_fin_addr  = r_addr[c_N-1];
      assign w_fin_data  = r_data[c_N-1];
      assign w_fin_err   = r_err[c_N-1];
    end else begin : g_resp_direct
      assign w_fin_valid = w_acc_valid;
      assign w_fin_addr  = w_acc_addr;
      assign w_fin_data  = w_acc_data;
      assign w_fin_err   = w_oob;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Show-ahead response FIFO; the outstanding limit keeps it from overflowing
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_fifo_addr [MAX_OUTSTANDING];
  logic [LINE_WIDTH-1:0] r_fifo_data [MAX_OUTSTANDING];
  logic                  r_fifo_err  [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [LINE_WIDTH-1:0] r_last_data;
  logic                  w_head_err;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // FIFO storage carries no reset; only valid entries are ever presented.
  always_ff @(posedge clk) begin
    if (w_fin_valid) begin
      r_fifo_addr[r_wr_ptr] <= w_fin_addr;
      r_fifo_data[r_wr_ptr] <= w_fin_data;
      r_fifo_err[r_wr_ptr]  <= w_fin_err;
    end
  end

  // FIFO pointers, occupancy, and the last-popped response held while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      if (w_fin_valid) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr    <= f_ptr_inc(r_rd_ptr);
        r_last_addr <= r_fifo_addr[r_rd_ptr];
        r_last_data <= r_fifo_data[r_rd_ptr];
      end
      if (w_fin_valid && !w_pop) begin
        r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
      end else if (!w_fin_valid && w_pop) begin
        r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
      end
    end
  end

  assign w_head_err     = r_fifo_err[r_rd_ptr];
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_addr  = w_resp_valid ? r_fifo_addr[r_rd_ptr] : r_last_addr;
  assign bus.resp_data  = w_resp_valid ? r_fifo_data[r_rd_ptr] : r_last_data;

`ifdef BRISC_LINE_MEM_BOUNDS_EN
  logic r_last_err;

  // Error flag of the last popped response, shown while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_err <= 1'b0;
    end else if (w_pop) begin
      r_last_err <= w_head_err;
    end
  end

  assign bus.resp_err = w_resp_valid ? w_head_err : r_last_err;
`else
  logic w_unused_err;
  assign w_unused_err = w_head_err;
`endif

endmodule
`default_nettype wire
